// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync-header codes, the block-lock state type
// and the header classification helper.
package pcs_pkg;

   localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
   localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

   typedef enum logic [1:0] {
      RESET_CNT,
      TEST_SH,
      SLIP,
      SLIP_HOLD
   } lock_state_t;

   function automatic logic sh_is_valid(input logic [1:0] hdr);
      return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_CTRL);
   endfunction

endpackage

// File: rtl/block_lock_fsm_if.sv
// Gearbox-to-lock-controller bundle. The master drives headers and the error
// clear; the slave (lock controller) returns slip, lock, error count and state.
interface block_lock_fsm_if #(
   parameter int HDR_WIDTH     = 2,
   parameter int ERR_CNT_WIDTH = 16
);
   // Handshake: i_sync_hdr is consumed only on cycles with i_hdr_valid=1; there is
   // no back-pressure, so every strobed header is taken in the cycle it is offered.
   logic [HDR_WIDTH-1:0]     i_sync_hdr;
   logic                     i_hdr_valid;
   logic                     i_err_cnt_clr;
   logic                     o_slip;
   logic                     o_block_lock;
   logic [ERR_CNT_WIDTH-1:0] o_hdr_err_cnt;
   pcs_pkg::lock_state_t     o_state;

   modport master (
      output i_sync_hdr, i_hdr_valid, i_err_cnt_clr,
      input  o_slip, o_block_lock, o_hdr_err_cnt, o_state
   );

   modport slave (
      input  i_sync_hdr, i_hdr_valid, i_err_cnt_clr,
      output o_slip, o_block_lock, o_hdr_err_cnt, o_state
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_inc && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/block_lock_fsm.sv
// 64b/66b block-lock controller: slips the gearbox until sync headers line up,
// then holds lock until too many invalid headers land in one test window.
module block_lock_fsm
   import pcs_pkg::*;
#(
   parameter int HDR_WIDTH     = 2,
   parameter int SH_WINDOW     = 64,
   parameter int INVALID_MAX   = 16,
   parameter int SLIP_WAIT     = 4,
   parameter int ERR_CNT_WIDTH = 16
) (
   input logic            i_clk,
   input logic            i_reset,
   block_lock_fsm_if.slave bus
);

   localparam int SH_CNT_W  = $clog2(SH_WINDOW) + 1;
   localparam int INV_CNT_W = $clog2(INVALID_MAX + 1);
   localparam int WAIT_W    = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

   lock_state_t          state_q, state_d;
   logic [SH_CNT_W-1:0]  sh_cnt_q, sh_cnt_d, sh_cnt_inc;
   logic [INV_CNT_W-1:0] inv_cnt_q, inv_cnt_d, inv_cnt_inc;
   logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                 lock_q, lock_d;
   logic                 slip_q, slip_d;
   logic                 err_inc;
   logic [HDR_WIDTH-1:0] hdr;
   logic                 hdr_ok;

   assign hdr         = bus.i_sync_hdr;
   assign hdr_ok      = sh_is_valid(hdr);
   assign sh_cnt_inc  = sh_cnt_q + SH_CNT_W'(1);
   assign inv_cnt_inc = inv_cnt_q + INV_CNT_W'(!hdr_ok);

   always_comb begin
      state_d    = state_q;
      sh_cnt_d   = sh_cnt_q;
      inv_cnt_d  = inv_cnt_q;
      wait_cnt_d = wait_cnt_q;
      lock_d     = lock_q;
      err_inc    = 1'b0;
      case (state_q)
         RESET_CNT: begin
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
            state_d   = TEST_SH;
         end
         TEST_SH: begin
            if (bus.i_hdr_valid) begin
               sh_cnt_d  = sh_cnt_inc;
               inv_cnt_d = inv_cnt_inc;
               err_inc   = lock_q && !hdr_ok;
               // Loss of lock is checked before window completion so it wins on the last header.
               if (!lock_q && !hdr_ok) begin
                  state_d = SLIP;
               end else if (lock_q && (inv_cnt_inc == INV_CNT_W'(INVALID_MAX))) begin
                  lock_d  = 1'b0;
                  state_d = SLIP;
               end else if (sh_cnt_inc == SH_CNT_W'(SH_WINDOW)) begin
                  lock_d  = 1'b1;
                  state_d = RESET_CNT;
               end
            end
         end
         SLIP: begin
            wait_cnt_d = '0;
            state_d    = SLIP_HOLD;
         end
         SLIP_HOLD: begin
            if (SLIP_WAIT == 0) begin
               state_d = RESET_CNT;
            end else if (bus.i_hdr_valid) begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               if (wait_cnt_d == WAIT_W'(SLIP_WAIT)) begin
                  state_d = RESET_CNT;
               end
            end
         end
         default: state_d = RESET_CNT;
      endcase
      slip_d = (state_d == SLIP);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= RESET_CNT;
         sh_cnt_q   <= '0;
         inv_cnt_q  <= '0;
         wait_cnt_q <= '0;
         lock_q     <= 1'b0;
         slip_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_cnt_q   <= sh_cnt_d;
         inv_cnt_q  <= inv_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         lock_q     <= lock_d;
         slip_q     <= slip_d;
      end
   end

   sat_counter #(
      .WIDTH(ERR_CNT_WIDTH)
   ) u_err_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (err_inc),
      .i_clr   (bus.i_err_cnt_clr),
      .o_cnt   (bus.o_hdr_err_cnt)
   );

   assign bus.o_slip       = slip_q;
   assign bus.o_block_lock = lock_q;
   assign bus.o_state      = state_q;

endmodule
